approx_rca_pipe: RTL

//  Parametrised, pipelined ripple-carry adder for delay/MSE characterisation.
//  The low APPROX_BITS positions use the approximate cell (S = Y&(X|Z), Cout = X|~Y).
//  The remaining positions use exact full adders.
//  A runtime mode selects approximate or exact operation for each transaction.
//  A shadow exact sum drives an on-line error monitor; the block sits between operand source and characterisation sink.

---
 rtl/approx_add_pkg.sv | 25 ++
 rtl/approx_rca_seg.sv | 39 +++
 rtl/approx_rca_pipe.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/approx_add_pkg.sv
// ============================================================================
// approx_add_pkg : bit-cell functions and configuration checks shared by the
//                  approximate ripple-carry adder pipeline.
// Revision 1.0
// ============================================================================
`default_nettype none

package approx_add_pkg;

    // Approximate cell: S = Y & (X | Z), Cout = X | ~Y. Result packed as {cout, s}.
    function automatic logic [1:0] approx_cell(input logic x, input logic y, input logic z);
        return {x | ~y, y & (x | z)};
    endfunction

    function automatic logic [1:0] exact_cell(input logic x, input logic y, input logic z);
        return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
    endfunction

    function automatic bit seg_fits(input int width, input int stages);
        return (stages > 0) && ((width % stages) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/approx_rca_seg.sv
// ============================================================================
// approx_rca_seg : combinational SEG-bit ripple segment; each bit selects the
//                  approximate or exact cell through approx_mask.
// Revision 1.0
// ============================================================================
`default_nettype none

module approx_rca_seg
    import approx_add_pkg::*;
#(
    parameter int SEG  = 8,
    parameter int BASE = 0
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    input  logic [SEG-1:0] approx_mask,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    logic [SEG:0] w_c;

    assign w_c[0] = cin;

    for (genvar j = 0; j < SEG; j++) begin : g_bit
        assign {w_c[j+1], sum[j]} = approx_mask[j] ? approx_cell(a[j], b[j], w_c[j])
                                                   : exact_cell(a[j], b[j], w_c[j]);
    end

    assign cout = w_c[SEG];

    if ((BASE % SEG) != 0) begin : g_base_check
        $error("approx_rca_seg: BASE must be a multiple of SEG");
    end

endmodule

`default_nettype wire

// File: rtl/approx_rca_pipe.sv
// ============================================================================
// approx_rca_pipe : pipelined approximate/exact ripple-carry adder with an
//                   exact shadow path and saturating error statistics.
// Revision 1.0
// ============================================================================
`default_nettype none

module approx_rca_pipe
    import approx_add_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 8,
    parameter int STAGES      = 2,
    parameter int ERR_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] err_abs,
    input  logic             clr_stats
);

    localparam int SEG    = WIDTH / STAGES;
    localparam int LAST   = STAGES - 1;
    localparam bit CFG_OK = seg_fits(WIDTH, STAGES);
    localparam logic [WIDTH-1:0] APPROX_POS = {WIDTH{1'b1}} >> (WIDTH - APPROX_BITS);
    localparam int ACC_W  = ((ERR_W > WIDTH + 1) ? ERR_W : WIDTH + 1) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'({ERR_W{1'b1}});

    if (!CFG_OK) begin : g_cfg_check
        $error("approx_rca_pipe: STAGES must divide WIDTH");
    end

    // r_x[k] holds {operand A bits not yet added, sum bits already produced};
    // r_y[k] holds the same split for operand B and the exact shadow sum.
    logic [STAGES-1:0]            r_valid, r_mode, r_c, r_ec;
    logic [STAGES-1:0][WIDTH-1:0] r_x, r_y;

    logic [STAGES-1:0][WIDTH-1:0] w_xin, w_yin;
    logic [STAGES-1:0]            w_vin, w_min, w_cin, w_ecin;
    logic [STAGES-1:0][SEG-1:0]   w_s, w_es;
    logic [STAGES-1:0]            w_co, w_eco;
    logic                         w_stall;
    logic [WIDTH:0]               w_exact, w_diff;
    logic [ACC_W-1:0]             w_cnt_next, w_abs_next;
    logic [ERR_W-1:0]             r_err_cnt, r_err_abs;

    function automatic logic [WIDTH-1:0] seg_field(input int k);
        return WIDTH'({SEG{1'b1}}) << (k * SEG);
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_xin[k] = in_a;
            assign w_yin[k] = in_b;
            assign w_vin[k] = in_valid;
            assign w_min[k] = in_approx;
            assign w_cin[k] = 1'b0;
            assign w_ecin[k] = 1'b0;
        end else begin : g_body
            assign w_xin[k] = r_x[k-1];
            assign w_yin[k] = r_y[k-1];
            assign w_vin[k] = r_valid[k-1];
            assign w_min[k] = r_mode[k-1];
            assign w_cin[k] = r_c[k-1];
            assign w_ecin[k] = r_ec[k-1];
        end

        approx_rca_seg #(.SEG(SEG), .BASE(k * SEG)) u_main (
            .a           (w_xin[k][k*SEG +: SEG]),
            .b           (w_yin[k][k*SEG +: SEG]),
            .cin         (w_cin[k]),
            .approx_mask ({SEG{w_min[k]}} & APPROX_POS[k*SEG +: SEG]),
            .sum         (w_s[k]),
            .cout        (w_co[k])
        );

        approx_rca_seg #(.SEG(SEG), .BASE(k * SEG)) u_shadow (
            .a           (w_xin[k][k*SEG +: SEG]),
            .b           (w_yin[k][k*SEG +: SEG]),
            .cin         (w_ecin[k]),
            .approx_mask ({SEG{1'b0}}),
            .sum         (w_es[k]),
            .cout        (w_eco[k])
        );
    end

    assign w_stall  = r_valid[LAST] & ~out_ready;
    assign in_ready = ~w_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_mode  <= '0;
            r_c     <= '0;
            r_ec    <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else if (!w_stall) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= w_vin[k];
                r_mode[k]  <= w_min[k];
                r_c[k]     <= w_co[k];
                r_ec[k]    <= w_eco[k];
                r_x[k]     <= (w_xin[k] & ~seg_field(k)) | (WIDTH'(w_s[k]) << (k * SEG));
                r_y[k]     <= (w_yin[k] & ~seg_field(k)) | (WIDTH'(w_es[k]) << (k * SEG));
            end
        end
    end

    assign out_valid = r_valid[LAST];
    assign out_sum   = {r_c[LAST], r_x[LAST]};
    assign w_exact   = {r_ec[LAST], r_y[LAST]};
    assign out_err   = r_mode[LAST] & (out_sum != w_exact);
    assign w_diff    = (out_sum >= w_exact) ? (out_sum - w_exact) : (w_exact - out_sum);

    // Accumulators are widened by one bit beyond both operands so overflow
    // shows up as a value above the all-ones limit.
    assign w_cnt_next = ACC_W'(r_err_cnt) + ACC_W'(out_err);
    assign w_abs_next = ACC_W'(r_err_abs) + ACC_W'(w_diff);

    always_ff @(posedge clk) begin
        if (!rst_n || clr_stats) begin
            r_err_cnt <= '0;
            r_err_abs <= '0;
        end else if (out_valid && out_ready) begin
            r_err_cnt <= (w_cnt_next > ACC_MAX) ? {ERR_W{1'b1}} : w_cnt_next[ERR_W-1:0];
            r_err_abs <= (w_abs_next > ACC_MAX) ? {ERR_W{1'b1}} : w_abs_next[ERR_W-1:0];
        end
    end

    assign err_cnt = r_err_cnt;
    assign err_abs = r_err_abs;

endmodule

`default_nettype wire
